regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RD, RD_DATA, reg_write_enable) between two writeback requesters.
- Requester A is the ALU path and has priority. Requester B is the load/store path.
- B is protected from starvation by a bounded wait counter.
- Write-port outputs are registered, so the block sits between the execute/memory stages and RegFile.

---
 rtl/regfile_wb_arbiter.sv | 83 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register-file write port
module regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            A_VALID,
    input  logic [4:0]      A_RD,
    input  logic [XLEN-1:0] A_DATA,
    output logic            A_READY,
    input  logic            B_VALID,
    input  logic [4:0]      B_RD,
    input  logic [XLEN-1:0] B_DATA,
    output logic            B_READY,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] RD_DATA,
    output logic            reg_write_enable,
    output logic [3:0]      STARVE_CNT
);

    // Wait limit in counter width; legal range 1..15 fits in four bits.
    localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

    logic            force_b;
    logic            grant_a;
    logic            grant_b;
    logic            win_any;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    // Priority grant: A wins unless B has waited MAX_WAIT cycles. READY never
    // looks at the requester's own VALID, so no loop forms through a requester.
    always_comb begin
        force_b  = (STARVE_CNT == MAX_WAIT_CNT);
        grant_b  = B_VALID & (~A_VALID | force_b);
        grant_a  = A_VALID & ~grant_b;
        A_READY  = ~(B_VALID & force_b) | FLUSH;
        B_READY  = ~A_VALID | force_b | FLUSH;
        win_any  = grant_a | grant_b;
        win_rd   = grant_b ? B_RD : A_RD;
        win_data = grant_b ? B_DATA : A_DATA;
    end

    // Registered write port: winner appears one cycle after its handshake.
    // Flushed cycles and x0 destinations produce no strobe; x0 also zeroes the
    // address/data so nothing stale is presented with a dropped write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            reg_write_enable <= 1'b0;
            RD               <= '0;
            RD_DATA          <= '0;
        end else if (FLUSH) begin
            reg_write_enable <= 1'b0;
        end else if (win_any) begin
            if (win_rd == 5'd0) begin
                reg_write_enable <= 1'b0;
                RD               <= '0;
                RD_DATA          <= '0;
            end else begin
                reg_write_enable <= 1'b1;
                RD               <= win_rd;
                RD_DATA          <= win_data;
            end
        end else begin
            reg_write_enable <= 1'b0;
        end
    end

    // Starvation counter: counts consecutive refused B cycles, cleared whenever
    // B is served, withdraws, or the pipeline is flushed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STARVE_CNT <= '0;
        end else if (FLUSH || grant_b || !B_VALID) begin
            STARVE_CNT <= '0;
        end else if (STARVE_CNT != MAX_WAIT_CNT) begin
            STARVE_CNT <= STARVE_CNT + 4'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        A_VALID = 1'b0;
    logic [4:0]  A_RD = '0;
    logic [31:0] A_DATA = '0;
    logic        A_READY;
    logic        B_VALID = 1'b0;
    logic [4:0]  B_RD = '0;
    logic [31:0] B_DATA = '0;
    logic        B_READY;
    logic [4:0]  RD;
    logic [31:0] RD_DATA;
    logic        reg_write_enable;
    logic [3:0]  STARVE_CNT;

    regfile_wb_arbiter #(.XLEN(32), .MAX_WAIT(3)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .A_VALID(A_VALID), .A_RD(A_RD), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_RD(B_RD), .B_DATA(B_DATA), .B_READY(B_READY),
        .RD(RD), .RD_DATA(RD_DATA), .reg_write_enable(reg_write_enable),
        .STARVE_CNT(STARVE_CNT)
    );

    always #5 CLK = ~CLK;

    typedef enum logic [1:0] {K_NONE, K_WRITE, K_ZERO} kind_t;

    typedef struct {
        logic        fl;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        ea;
        logic        eb;
        logic [3:0]  ecnt;
        kind_t       kind;
        logic [4:0]  wrd;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic ea, input logic eb, input logic [3:0] ecnt,
                       input kind_t kind, input logic [4:0] wrd, input logic [31:0] wdata);
        vec_t v;
        v.fl = fl; v.av = av; v.ard = ard; v.ad = ad;
        v.bv = bv; v.brd = brd; v.bd = bd;
        v.ea = ea; v.eb = eb; v.ecnt = ecnt;
        v.kind = kind; v.wrd = wrd; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET && reg_write_enable) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_write", {27'd0, RD}, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = sb.pop_front();
                    check("sb_rd", {27'd0, RD}, {27'd0, w.rd});
                    check("sb_data", RD_DATA, w.data);
                end
            end
        end
    end

    initial begin
        kind_t       prev_kind;
        logic [4:0]  hold_rd;
        logic [31:0] hold_data;

        //  fl av ard ad     bv brd bd     ea eb cnt kind     wrd wdata
        add(0, 1, 5,  42,    0, 0,  0,     1, 0, 0, K_WRITE, 5,  42);   // first write after reset
        add(0, 1, 1,  5,     0, 0,  0,     1, 0, 0, K_WRITE, 1,  5);    // single A
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);
        add(0, 1, 2,  10,    1, 3,  99,    1, 0, 0, K_WRITE, 2,  10);   // priority
        add(0, 0, 0,  0,     1, 3,  99,    1, 1, 1, K_WRITE, 3,  99);
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);
        add(0, 1, 8,  11,    1, 4,  7,     1, 0, 0, K_WRITE, 8,  11);   // starvation
        add(0, 1, 9,  12,    1, 4,  7,     1, 0, 1, K_WRITE, 9,  12);
        add(0, 1, 10, 13,    1, 4,  7,     1, 0, 2, K_WRITE, 10, 13);
        add(0, 1, 11, 14,    1, 4,  7,     0, 1, 3, K_WRITE, 4,  7);    // forced B
        add(0, 1, 11, 14,    0, 0,  0,     1, 0, 0, K_WRITE, 11, 14);   // stalled A
        add(0, 1, 6,  1,     1, 6,  2,     1, 0, 0, K_WRITE, 6,  1);    // same rd
        add(0, 0, 0,  0,     1, 6,  2,     1, 1, 1, K_WRITE, 6,  2);
        add(0, 1, 0,  99,    0, 0,  0,     1, 0, 0, K_ZERO,  0,  0);    // x0 drop
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);
        add(0, 1, 12, 4,     1, 7,  3,     1, 0, 0, K_WRITE, 12, 4);    // flush
        add(1, 1, 13, 5,     1, 7,  3,     1, 1, 1, K_NONE,  0,  0);
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);
        add(0, 1, 14, 6,     1, 15, 8,     1, 0, 0, K_WRITE, 14, 6);    // B drop
        add(0, 1, 16, 9,     0, 0,  0,     1, 0, 1, K_WRITE, 16, 9);
        add(0, 0, 0,  0,     1, 15, 8,     1, 1, 0, K_WRITE, 15, 8);
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);    // hold values
        add(0, 0, 0,  0,     0, 0,  0,     1, 1, 0, K_NONE,  0,  0);

        // Reset held with an A request pending: nothing may be written.
        RESET = 1'b1; A_VALID = 1'b1; A_RD = 5'd5; A_DATA = 32'd42;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_we", {31'd0, reg_write_enable}, 32'd0);
            check("rst_cnt", {28'd0, STARVE_CNT}, 32'd0);
        end

        prev_kind = K_NONE;
        hold_rd   = '0;
        hold_data = '0;
        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            RESET   = 1'b0;
            FLUSH   = vecs[i].fl;
            A_VALID = vecs[i].av; A_RD = vecs[i].ard; A_DATA = vecs[i].ad;
            B_VALID = vecs[i].bv; B_RD = vecs[i].brd; B_DATA = vecs[i].bd;
            @(negedge CLK);
            check($sformatf("a_ready[%0d]", i), {31'd0, A_READY}, {31'd0, vecs[i].ea});
            check($sformatf("b_ready[%0d]", i), {31'd0, B_READY}, {31'd0, vecs[i].eb});
            check($sformatf("starve_cnt[%0d]", i), {28'd0, STARVE_CNT}, {28'd0, vecs[i].ecnt});
            check($sformatf("we[%0d]", i), {31'd0, reg_write_enable},
                  {31'd0, prev_kind == K_WRITE});
            if (prev_kind != K_WRITE) begin
                check($sformatf("rd_hold[%0d]", i), {27'd0, RD}, {27'd0, hold_rd});
                check($sformatf("data_hold[%0d]", i), RD_DATA, hold_data);
            end
            if (vecs[i].kind == K_WRITE) begin
                wr_t w;
                w.rd = vecs[i].wrd;
                w.data = vecs[i].wdata;
                sb.push_back(w);
                hold_rd = vecs[i].wrd;
                hold_data = vecs[i].wdata;
            end else if (vecs[i].kind == K_ZERO) begin
                hold_rd = '0;
                hold_data = '0;
            end
            prev_kind = vecs[i].kind;
        end

        // Reset asserted while a write is on the port drops the strobe at once.
        @(posedge CLK);
        #1;
        FLUSH = 1'b0; B_VALID = 1'b0;
        A_VALID = 1'b1; A_RD = 5'd17; A_DATA = 32'd21;
        @(posedge CLK);
        #1;
        A_VALID = 1'b0;
        check("midrst_we_before", {31'd0, reg_write_enable}, 32'd1);
        check("midrst_rd_before", {27'd0, RD}, 32'd17);
        #1;
        RESET = 1'b1;
        #1;
        check("midrst_we_after", {31'd0, reg_write_enable}, 32'd0);
        check("midrst_rd_after", {27'd0, RD}, 32'd0);
        check("midrst_data_after", RD_DATA, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("midrst_we_hold", {31'd0, reg_write_enable}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
